// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_SLT = 3'b010;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_SLT = 2'b10;

    // True for every opcode/funct pair the datapath can execute.
    function automatic logic is_legal(input logic [3:0] op, input logic [2:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT);
            OP_LW, OP_SW, OP_BEQ, OP_HALT: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // R-type funct to ALU operation; only called for legal functs.
    function automatic logic [1:0] funct_to_alu(input logic [2:0] funct);
        logic [1:0] op;
        op = ALU_ADD;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational control decode: state plus latched op/funct to datapath controls.
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic       [2:0] state_i,
    input  logic       [3:0] op_i,
    input  logic       [2:0] funct_i,
    input  logic             alu_zero_i,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic             reg_we_o,
    output logic             reg_dst_o,
    output logic             alu_src_o,
    output logic       [1:0] alu_op_o,
    output logic             mem_re_o,
    output logic             mem_we_o,
    output logic             wb_sel_o,
    output logic             illegal_o,
    output logic             halted_o
);

    state_e state;
    assign state = state_e'(state_i);

    // Moore decode; the beq PC enable is the only term gated by a live input.
    always_comb begin
        pc_we_o   = 1'b0;
        pc_src_o  = 1'b0;
        reg_we_o  = 1'b0;
        reg_dst_o = 1'b0;
        alu_src_o = 1'b0;
        alu_op_o  = ALU_ADD;
        mem_re_o  = 1'b0;
        mem_we_o  = 1'b0;
        wb_sel_o  = 1'b0;
        illegal_o = 1'b0;
        halted_o  = 1'b0;
        case (state)
            StFetch: pc_we_o = 1'b1;
            StDecode: illegal_o = !is_legal(op_i, funct_i);
            StExec: begin
                case (op_i)
                    OP_RTYPE: alu_op_o = funct_to_alu(funct_i);
                    OP_LW, OP_SW: alu_src_o = 1'b1;
                    OP_BEQ: begin
                        alu_op_o = ALU_SUB;
                        pc_src_o = 1'b1;
                        pc_we_o  = alu_zero_i;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                alu_src_o = 1'b1;
                mem_re_o  = (op_i == OP_LW);
                mem_we_o  = (op_i == OP_SW);
            end
            StWb: begin
                reg_we_o = 1'b1;
                if (op_i == OP_LW) begin
                    alu_src_o = 1'b1;
                    wb_sel_o  = 1'b1;
                end else begin
                    reg_dst_o = 1'b1;
                    alu_op_o  = funct_to_alu(funct_i);
                end
            end
            StHalt: halted_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer: state register, op/funct latch, optional counters.
// Optional performance counters are built when CPU_CTRL_PERF_EN is defined.
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic       [15:0] instr,
    input  logic              alu_zero,
    output logic              pc_we,
    output logic              pc_src,
    output logic              reg_we,
    output logic              reg_dst,
    output logic              alu_src,
    output logic       [1:0]  alu_op,
    output logic              mem_re,
    output logic              mem_we,
    output logic              wb_sel,
    output logic              illegal,
    output logic              halted
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  inst_cnt
`endif
);

    state_e     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [2:0] funct_q, funct_d;

    // Register fields other than op/funct belong to the datapath.
    logic unused_instr;
    assign unused_instr = ^instr[11:3];

    // Next state and op/funct capture on the FETCH->DECODE edge.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        case (state_q)
            StIdle: if (START) state_d = StFetch;
            StFetch: begin
                state_d = StDecode;
                op_d    = instr[15:12];
                funct_d = instr[2:0];
            end
            StDecode: begin
                if (!is_legal(op_q, funct_q)) state_d = StFetch;
                else if (op_q == OP_HALT)     state_d = StHalt;
                else                          state_d = StExec;
            end
            StExec: begin
                if (op_q == OP_RTYPE)                        state_d = StWb;
                else if ((op_q == OP_LW) || (op_q == OP_SW)) state_d = StMem;
                else                                         state_d = StFetch;
            end
            StMem:  state_d = (op_q == OP_LW) ? StWb : StFetch;
            StWb:   state_d = StFetch;
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    // State and latched instruction fields.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            op_q    <= OP_RTYPE;
            funct_q <= FN_ADD;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    cpu_ctrl_decode u_decode (
        .state_i    (state_q),
        .op_i       (op_q),
        .funct_i    (funct_q),
        .alu_zero_i (alu_zero),
        .pc_we_o    (pc_we),
        .pc_src_o   (pc_src),
        .reg_we_o   (reg_we),
        .reg_dst_o  (reg_dst),
        .alu_src_o  (alu_src),
        .alu_op_o   (alu_op),
        .mem_re_o   (mem_re),
        .mem_we_o   (mem_we),
        .wb_sel_o   (wb_sel),
        .illegal_o  (illegal),
        .halted_o   (halted)
    );

`ifdef CPU_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_cnt_q, inst_cnt_q;

    // Active-cycle and fetch counters; both hold in IDLE and HALT.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc_cnt_q  <= '0;
            inst_cnt_q <= '0;
        end else begin
            if ((state_q != StIdle) && (state_q != StHalt)) cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
            if (state_q == StFetch) inst_cnt_q <= inst_cnt_q + CNT_W'(1);
        end
    end

    assign cyc_cnt  = cyc_cnt_q;
    assign inst_cnt = inst_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Self-checking bench for cpu_ctrl_fsm with an instruction-level reference model.
module tb_cpu_ctrl_fsm;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        START;
    logic [15:0] instr;
    logic        alu_zero;
    logic        pc_we, pc_src, reg_we, reg_dst, alu_src;
    logic [1:0]  alu_op;
    logic        mem_re, mem_we, wb_sel, illegal, halted;
`ifdef CPU_CTRL_PERF_EN
    logic [15:0] cyc_cnt, inst_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    cpu_ctrl_fsm #(.CNT_W(16)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .instr    (instr),
        .alu_zero (alu_zero),
        .pc_we    (pc_we),
        .pc_src   (pc_src),
        .reg_we   (reg_we),
        .reg_dst  (reg_dst),
        .alu_src  (alu_src),
        .alu_op   (alu_op),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .wb_sel   (wb_sel),
        .illegal  (illegal),
        .halted   (halted)
`ifdef CPU_CTRL_PERF_EN
        ,
        .cyc_cnt  (cyc_cnt),
        .inst_cnt (inst_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    logic [11:0] obs;
    assign obs = {pc_we, pc_src, reg_we, reg_dst, alu_src, alu_op,
                  mem_re, mem_we, wb_sel, illegal, halted};

    // Expected control word for cycle k (0 = fetch) of one instruction.
    function automatic logic [11:0] model(input logic [15:0] ins, input int k, input logic z);
        logic [3:0] op;
        logic [2:0] fn;
        logic pw, ps, rw, rd, as, mr, mw, wb, il, hl;
        logic [1:0] ao;
        bit r_ok, lw, sw, bq, ht;
        op = ins[15:12];
        fn = ins[2:0];
        {pw, ps, rw, rd, as, mr, mw, wb, il, hl} = '0;
        ao = 2'b00;
        r_ok = (op == 4'h0) && (fn <= 3'd2);
        lw = (op == 4'h4);
        sw = (op == 4'h5);
        bq = (op == 4'h6);
        ht = (op == 4'hF);
        if (k == 0) pw = 1'b1;
        else if (k == 1) il = !(r_ok || lw || sw || bq || ht);
        else if (ht) hl = 1'b1;
        else if (k == 2) begin
            if (r_ok) ao = fn[1:0];
            if (lw || sw) as = 1'b1;
            if (bq) begin
                ao = 2'b01;
                ps = 1'b1;
                pw = z;
            end
        end else if (k == 3) begin
            if (lw) begin mr = 1'b1; as = 1'b1; end
            if (sw) begin mw = 1'b1; as = 1'b1; end
            if (r_ok) begin rw = 1'b1; rd = 1'b1; ao = fn[1:0]; end
        end else if (k == 4 && lw) begin
            rw = 1'b1;
            wb = 1'b1;
            as = 1'b1;
        end
        return {pw, ps, rw, rd, as, ao, mr, mw, wb, il, hl};
    endfunction

    function automatic int n_cycles(input logic [15:0] ins);
        logic [3:0] op;
        op = ins[15:12];
        if (op == 4'h0 && ins[2:0] <= 3'd2) return 4;
        if (op == 4'h4) return 5;
        if (op == 4'h5) return 4;
        if (op == 4'h6) return 3;
        return 2;
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Entered #1 after the edge that starts the fetch; leaves likewise.
    // zmode: 0/1 force alu_zero, 2 random.
    task automatic run_instr(input logic [15:0] ins, input int zmode, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            instr    = (k == 0) ? ins : 16'($urandom);
            alu_zero = (zmode == 2) ? 1'($urandom) : zmode[0];
            START    = 1'($urandom);
            @(negedge CLK);
            check($sformatf("instr_%h_cyc%0d", ins, k), obs, model(ins, k, alu_zero));
            @(posedge CLK);
            #1;
        end
    endtask

    // Release reset, confirm IDLE holds without START, then start.
    task automatic start_from_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        check("idle_no_start", obs, 12'h000);
        START = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [15:0] rnd;
        logic [3:0]  ops [6];
        ops[0] = 4'h0; ops[1] = 4'h4; ops[2] = 4'h5;
        ops[3] = 4'h6; ops[4] = 4'h0; ops[5] = 4'h3;

        RST_N = 1'b1;
        START = 1'b0;
        instr = 16'h0;
        alu_zero = 1'b0;
        #1 RST_N = 1'b0;
        #1 check("reset_outputs", obs, 12'h000);
        start_from_reset();

        run_instr(16'h00D8, 2, n_cycles(16'h00D8));
        run_instr(16'h4102, 2, n_cycles(16'h4102));
        run_instr(16'h5102, 2, n_cycles(16'h5102));
        run_instr(16'h6243, 1, n_cycles(16'h6243));
        run_instr(16'h6243, 0, n_cycles(16'h6243));
        run_instr(16'h3000, 2, n_cycles(16'h3000));
        run_instr(16'h00DD, 2, n_cycles(16'h00DD));
        run_instr(16'h00D9, 2, n_cycles(16'h00D9));
        run_instr(16'h00DA, 2, n_cycles(16'h00DA));

        for (int i = 0; i < 150; i++) begin
            rnd = 16'($urandom);
            if ($urandom_range(0, 3) != 0) rnd[15:12] = ops[$urandom_range(0, 5)];
            if (rnd[15:12] == 4'hF) rnd[15:12] = 4'h0;
            run_instr(rnd, 2, n_cycles(rnd));
        end

        // Reset in the middle of a store's EXEC cycle.
        run_instr(16'h5102, 2, 2);
        @(negedge CLK);
        check("sw_exec_before_rst", obs, model(16'h5102, 2, alu_zero));
        #2 RST_N = 1'b0;
        #1 check("rst_async_mid_sw", obs, 12'h000);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check($sformatf("rst_hold_%0d", i), obs, 12'h000);
        end
        start_from_reset();

        // Halt, with START toggling while halted.
        run_instr(16'hF000, 2, 8);
        RST_N = 1'b0;
        #1 check("halt_reset", obs, 12'h000);
        start_from_reset();

        run_instr(16'h00D8, 2, n_cycles(16'h00D8));
        run_instr(16'h4102, 2, n_cycles(16'h4102));
        run_instr(16'hF000, 2, 6);
`ifdef CPU_CTRL_PERF_EN
        vectors++;
        assert (inst_cnt === 16'd3) else begin
            miscompares++;
            $error("FAIL inst_cnt: observed %0d expected 3", inst_cnt);
        end
        vectors++;
        assert (cyc_cnt === 16'd11) else begin
            miscompares++;
            $error("FAIL cyc_cnt: observed %0d expected 11", cyc_cnt);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
